sipo_frame_rx: RTL and testbench
================================

Name: sipo_frame_rx

Overview:
- Serial frame receiver that sits directly downstream of the siso4bit serial shift stage and consumes its `sout` bitstream, one bit per `clk`.
- Detects a start bit, shifts in DATA_W data bits LSB-first, checks even parity and the stop bit.
- Presents the recovered word on a one-entry valid/ready output register for the parallel consumer.
- Converts the serial chain back to a parallel word with error reporting.

Parameters:
- DATA_W, 4: data bits per frame; legal range 1..16.
- PARITY_EN, 1: 1 = a parity bit follows the data; 0 = no parity cycle.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
- sin  input  1  serial bit stream (upstream `sout`); idle level 1.
- dout  output  DATA_W  recovered word, bit 0 = first data bit received.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when high together with dout_valid.
- parity_err  output  1  qualifies dout: the word's parity check failed; valid only while dout_valid=1.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0; frame dropped.
- overrun  output  1  one-cycle pulse: a good frame completed while the holding register was full and not draining; new frame dropped.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; dout=0, dout_valid=0, parity_err=0, frame_err=0, overrun=0; shift counter=0.
  - Reset mid-frame abandons the frame and discards any held word.
- Frame format: start(0), DATA_W data bits LSB-first, parity (only if PARITY_EN, even: XOR of data and parity = 0), stop(1). One bit per edge, no oversampling.
- IDLE: sin=0 at an edge -> DATA with cnt=0. sin=1 -> stay in IDLE.
- DATA:
  - Each edge shifts sin into the shift register MSB, shifting right, so the first data bit ends at bit 0.
  - cnt increments each edge. When cnt=DATA_W-1, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: latch perr = (XOR of shifted data) ^ sin, then go to STOP.
- STOP (every exit returns to IDLE):
  - sin=1 -> frame good: attempt load into the holding register.
  - sin=0 -> frame_err=1 for the next cycle; no load.
- Holding register:
  - Load allowed when dout_valid=0, or when dout_valid=1 and dout_ready=1 on the same edge. On an allowed load, dout<=shift, parity_err<=perr, dout_valid<=1 (load wins over drain).
  - Load blocked (dout_valid=1 and dout_ready=0): dout is unchanged, overrun=1 for one cycle.
  - Drain without load: dout_valid=1 and dout_ready=1 -> dout_valid<=0; dout and parity_err hold their old values.
- dout and parity_err are stable while dout_valid=1 and dout_ready=0.
- Latency:
  - Start sampled at edge E0; stop sampled at edge E(DATA_W+1+PARITY_EN).
  - dout_valid=1 is visible immediately after that edge (DATA_W=4, PARITY_EN=1: after E6).
- Back-to-back frames: a start bit may be sampled at the edge right after the stop edge, with no idle bit needed.
- A 0 sampled in IDLE always starts a frame; there is no glitch filter because the upstream stage is synchronous.
- frame_err and overrun are registered, single-cycle pulses, mutually exclusive.

Decomposition:
- Shared package (siso_pkg):
  - State encoding localparams IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3.
  - Constant IDLE_LEVEL=1'b1.
  - Function even_parity(data).
- One sub-module: rx_hold_reg (DATA_W+1-bit one-entry valid/ready register).
  - Inputs: load, load_data, dout_ready.
  - Outputs: dout, parity_err, dout_valid, blocked (drives overrun).
- FSM, counter and shifter stay in the top level.

Test Plan:
- T1 basic, DATA_W=4, PARITY_EN=1, dout_ready=1: rst 2 cycles, sin=1 idle, then 0,1,1,0,1,1,1 -> after E6 dout=4'hB, dout_valid=1 for exactly one cycle, parity_err=0, no pulses.
- T2 parity error: frame 0,1,1,0,1,0,1 -> dout=4'hB, parity_err=1 while dout_valid=1.
- T3 framing error: 0,0,0,0,0,0,0 -> frame_err=1 one cycle after the stop edge, dout_valid stays 0, FSM returns to IDLE; next good frame for 4'h3 (0,1,1,0,0,0,1) delivers dout=4'h3.
- T4 backpressure/overrun: dout_ready=0, send 4'hB then back-to-back 4'h5 (0,1,0,1,0,0,1) -> dout stays 4'hB, overrun pulses once; raise dout_ready -> 4'hB accepted, then dout_valid=0.
- T5 simultaneous load/drain: hold 4'hB with ready=0, raise dout_ready=1 exactly on the stop edge of 4'h5 -> dout=4'h5, dout_valid stays 1, no overrun.
- T6 reset mid-frame: assert rst after 2 data bits for 1 cycle -> all outputs 0; a following full frame 4'hA (0,0,1,0,1,0,1) is received correctly.

Source files
------------

// File: rtl/siso_pkg.sv
// Shared definitions for the serial frame receiver: state encoding,
// line idle level and the parity helper used by the receive FSM.
package siso_pkg;

  // Receive FSM states; the encoding is fixed so debug probes can decode it.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Level of the serial line between frames.
  localparam logic IDLE_LEVEL = 1'b1;

  // Widest data word the receiver supports.
  localparam int MAX_DATA_W = 16;

  // XOR reduction of a zero-extended data word: 1 when it holds an odd number of ones.
  function automatic logic even_parity(input logic [MAX_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/rx_hold_reg.sv
// One-entry valid/ready output register holding a received word plus its
// parity flag.
//
// Handshake: a word moves to the consumer on any rising edge where
// dout_valid=1 and dout_ready=1. While dout_valid=1 and dout_ready=0 the
// contents are frozen. A load is accepted when the register is empty or
// draining on the same edge (load wins over drain); otherwise the new word
// is dropped and blocked pulses for one cycle.
module rx_hold_reg
  import siso_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W:0]   load_data,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout,
  output logic              parity_err,
  output logic              dout_valid,
  output logic              blocked
);

  logic load_ok;

  // A load fits when the slot is empty or is being emptied this edge.
  always_comb begin
    load_ok = load && (!dout_valid || dout_ready);
  end

  // Holding register: load, drain, or flag a dropped word.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      parity_err <= 1'b0;
      dout_valid <= 1'b0;
      blocked    <= 1'b0;
    end else begin
      blocked <= 1'b0;
      if (load_ok) begin
        dout       <= load_data[DATA_W-1:0];
        parity_err <= load_data[DATA_W];
        dout_valid <= 1'b1;
      end else if (load) begin
        blocked <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB-first, optional
// even parity bit, stop bit. One bit per clock, no oversampling. Good
// frames land in a one-entry valid/ready holding register; bad stop bits
// and dropped frames are reported as single-cycle pulses.
module sipo_frame_rx
  import siso_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int          CNT_W    = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   shift_next;
  logic                perr;
  logic                load;

  // New bits enter at the MSB so the first data bit ends at bit 0.
  if (DATA_W == 1) begin : g_shift_w1
    assign shift_next = sin;
  end else begin : g_shift_wn
    assign shift_next = {sin, shreg[DATA_W-1:1]};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a good stop bit requests a load into the holding register.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (sin != IDLE_LEVEL) state_next = DATA;
      end
      DATA: begin
        if (cnt == LAST_CNT) state_next = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: begin
        state_next = STOP;
      end
      STOP: begin
        state_next = IDLE;
        load       = sin;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit counter, shifter, parity latch and framing-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      shreg     <= '0;
      perr      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= (state == STOP) && !sin;
      case (state)
        IDLE: begin
          cnt  <= '0;
          perr <= 1'b0;
        end
        DATA: begin
          shreg <= shift_next;
          cnt   <= cnt + CNT_W'(1);
        end
        PARITY: begin
          perr <= even_parity(MAX_DATA_W'(shreg)) ^ sin;
        end
        default: ;
      endcase
    end
  end

  rx_hold_reg #(
    .DATA_W(DATA_W)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  ({perr, shreg}),
    .dout_ready (dout_ready),
    .dout       (dout),
    .parity_err (parity_err),
    .dout_valid (dout_valid),
    .blocked    (overrun)
  );

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx (DATA_W=4, PARITY_EN=1). Frames are composed
// into a per-cycle bit stream annotated with the frame outcome at each
// stop-bit edge; a word-level model of the output slot predicts the
// outputs after every edge.
module tb_sipo_frame_rx;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         sin;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         parity_err;
  logic         frame_err;
  logic         overrun;

  int tests = 0;
  int fails = 0;

  // Stream description: one entry per clock edge.
  logic         s_q[$];    // serial bit
  logic         r_q[$];    // dout_ready
  logic         x_q[$];    // rst
  int           ev_q[$];   // 0 none, 1 good frame ends, 2 bad stop bit
  logic [W-1:0] evd_q[$];  // frame data at the stop edge
  logic         evp_q[$];  // frame parity was corrupted

  // Words expected to be handed to the consumer, in order.
  logic [W-1:0] exp_q[$];

  // Model of the output slot.
  logic         mv;
  logic [W-1:0] md;
  logic         mp;
  logic         ef;
  logic         eo;

  logic rand_rdy;
  logic fixed_rdy;

  sipo_frame_rx #(
    .DATA_W   (W),
    .PARITY_EN(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int cyc, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push_bit(input logic b, input logic r, input int ev, input logic [W-1:0] d, input logic p);
    s_q.push_back(b);
    r_q.push_back(rand_rdy ? ($urandom_range(0, 3) != 0) : fixed_rdy);
    x_q.push_back(r);
    ev_q.push_back(ev);
    evd_q.push_back(d);
    evp_q.push_back(p);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) push_bit(1'b1, 1'b0, 0, '0, 1'b0);
  endtask

  task automatic add_rst(input int n);
    for (int i = 0; i < n; i++) push_bit(1'b1, 1'b1, 0, '0, 1'b0);
  endtask

  // Start, data LSB-first, even parity (optionally inverted), stop (optionally 0).
  task automatic add_frame(input logic [W-1:0] d, input logic par_bad, input logic stop_bad);
    push_bit(1'b0, 1'b0, 0, '0, 1'b0);
    for (int i = 0; i < W; i++) push_bit(d[i], 1'b0, 0, '0, 1'b0);
    push_bit((^d) ^ par_bad, 1'b0, 0, '0, 1'b0);
    push_bit(!stop_bad, 1'b0, stop_bad ? 2 : 1, d, par_bad);
  endtask

  // Drive the stream edge by edge, update the model and compare.
  task automatic run_stream();
    logic [W-1:0] w;
    for (int i = 0; i < s_q.size(); i++) begin
      sin        = s_q[i];
      dout_ready = r_q[i];
      rst        = x_q[i];
      // Consumer side: a word is taken at this edge.
      if (!x_q[i] && mv && r_q[i]) begin
        w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check("accepted_word", i, 16'(dout), 16'(w));
      end
      @(posedge clk);
      #1;
      if (x_q[i]) begin
        mv = 1'b0; md = '0; mp = 1'b0; ef = 1'b0; eo = 1'b0;
        exp_q.delete();
      end else begin
        ef = (ev_q[i] == 2);
        eo = 1'b0;
        if (ev_q[i] == 1) begin
          if (!mv || r_q[i]) begin
            md = evd_q[i];
            mp = evp_q[i];
            mv = 1'b1;
            exp_q.push_back(evd_q[i]);
          end else begin
            eo = 1'b1;
          end
        end else if (mv && r_q[i]) begin
          mv = 1'b0;
        end
      end
      check("dout_valid", i, 16'(dout_valid), 16'(mv));
      check("dout", i, 16'(dout), 16'(md));
      check("parity_err", i, 16'(parity_err), 16'(mp));
      check("frame_err", i, 16'(frame_err), 16'(ef));
      check("overrun", i, 16'(overrun), 16'(eo));
    end
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    rst = 1'b1; sin = 1'b1; dout_ready = 1'b0;
    mv = 1'b0; md = '0; mp = 1'b0; ef = 1'b0; eo = 1'b0;
    rand_rdy = 1'b0; fixed_rdy = 1'b1;

    // Reset, then a clean 4'hB frame consumed immediately.
    add_rst(2);
    add_idle(2);
    add_frame(4'hB, 1'b0, 1'b0);
    add_idle(3);

    // Parity error on 4'hB.
    add_frame(4'hB, 1'b1, 1'b0);
    add_idle(2);

    // All-zero line: bad stop bit, then a good 4'h3.
    add_frame(4'h0, 1'b0, 1'b1);
    add_frame(4'h3, 1'b0, 1'b0);
    add_idle(2);

    // Backpressure: 4'hB held, back-to-back 4'h5 dropped, then drain.
    fixed_rdy = 1'b0;
    add_frame(4'hB, 1'b0, 1'b0);
    add_frame(4'h5, 1'b0, 1'b0);
    add_idle(2);
    fixed_rdy = 1'b1;
    add_idle(2);

    // Ready rises exactly on the stop edge of 4'h5: load and drain together.
    fixed_rdy = 1'b0;
    add_frame(4'hB, 1'b0, 1'b0);
    add_frame(4'h5, 1'b0, 1'b0);
    r_q[r_q.size() - 1] = 1'b1;
    add_idle(2);
    fixed_rdy = 1'b1;
    add_idle(2);

    // Reset mid-frame with a word held, then a clean 4'hA.
    fixed_rdy = 1'b0;
    add_frame(4'h6, 1'b0, 1'b0);
    push_bit(1'b0, 1'b0, 0, '0, 1'b0);
    push_bit(1'b0, 1'b0, 0, '0, 1'b0);
    push_bit(1'b1, 1'b0, 0, '0, 1'b0);
    add_rst(1);
    fixed_rdy = 1'b1;
    add_idle(1);
    add_frame(4'hA, 1'b0, 1'b0);
    add_idle(2);

    // Random frames, errors, gaps and consumer stalls.
    rand_rdy = 1'b1;
    for (int f = 0; f < 40; f++) begin
      add_frame(W'($urandom_range(0, 15)),
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 5) == 0);
      add_idle($urandom_range(0, 2));
    end
    rand_rdy = 1'b0;
    fixed_rdy = 1'b1;
    add_idle(4);

    run_stream();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
